adc_lane_rx: RTL and testbench
==============================

# adc_lane_rx

Receive-side capture block for the 8-way time-interleaved SAR ADC. It sits in the digital core and is clocked by the ADC's divided core clock (`clkout_des`). Every cycle it samples the eight parallel offset-binary sub-ADC words and converts them to two's complement. It then subtracts a per-lane offset, saturates, and buffers the resulting vectors into a valid/ready stream. It also includes a background calibration engine that measures each lane's mean and loads it as that lane's offset.

## Interface
- `WAYS`, 8: number of interleaved lanes.
- `BITS`, 9: sub-ADC word width.
- `FIFO_DEPTH`, 4: output FIFO depth in vectors; must be ≥2.
- `AVG_LOG2`, 8: log2 of the number of vectors averaged per calibration.

Ports:
- `clk` in 1: core clock, same domain as the ADC retimed outputs.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: capture enable.
- `adc_data_in` in WAYS*BITS: lane i at `[i*BITS +: BITS]`, offset binary, lane 0 is the earliest sample.
- `offs_wr` in 1: manual offset write strobe.
- `offs_lane` in $clog2(WAYS): lane selected for the manual write.
- `offs_val` in BITS: signed offset value to write.
- `cal_start` in 1: single-cycle calibration request.
- `cal_busy` out 1: high while calibration runs.
- `cal_done` out 1: single-cycle pulse when offsets are loaded.
- `out_data` out WAYS*BITS: corrected vector, signed, same lane layout as `adc_data_in`.
- `out_valid` out 1; `out_ready` in 1: stream handshake.
- `ovf` out 1: sticky overflow flag. `clr_ovf` in 1: clears `ovf`.

## Operation
- Conversion: `conv[i] = {~in[i][BITS-1], in[i][BITS-2:0]}`, which maps 0→−256, 256→0, 511→+255.
- Correction: `corr[i] = sat(conv[i] − offset[i])`.
  - Compute the difference at BITS+1 width.
  - Clamp to [−2^(BITS−1), 2^(BITS−1)−1].
- Offset registers: WAYS × BITS signed, reset value 0.
  - `offs_wr` writes `offs_val` to `offset[offs_lane]` on the next edge.
  - A same-cycle write from the LOAD state takes priority.
- Pipeline: while `en`=1, stage register S1 captures `corr` every edge. S1 valid = `en` delayed one cycle. A valid S1 is pushed into the FIFO on the following edge.
- FIFO push/pop rules:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the vector is dropped and `ovf` is set.
  - `ovf` clears only on `clr_ovf`; if a set and `clr_ovf` coincide, set wins.
- Output: `out_valid` = FIFO not empty. `out_data` = FIFO head, held stable while `out_valid`=1 and `out_ready`=0.
- Calibration FSM states: IDLE, ACC, LOAD.
  - IDLE→ACC: on `cal_start`=1 and `en`=1. Clears the WAYS accumulators (signed, BITS+AVG_LOG2 wide) and the vector counter. `cal_start` with `en`=0 is ignored.
  - ACC: each cycle with `en`=1, adds `conv[i]` (uncorrected) to `acc[i]` and increments the counter. `cal_start` is ignored.
  - ACC→LOAD: after 2^AVG_LOG2 vectors have been accumulated.
  - ACC→IDLE (abort): when `en`=0. Offsets are left unchanged and no `cal_done` is issued.
  - LOAD→IDLE: after one cycle. Sets `offset[i] = acc[i] >>> AVG_LOG2` (arithmetic shift, floor) and pulses `cal_done`.
- `cal_busy` = state ≠ IDLE. Streaming continues throughout calibration, using the old offsets until LOAD.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `ovf`=0, `cal_busy`=0, `cal_done`=0.
  - FIFO empty, S1 invalid, FSM in IDLE, offsets 0.
- Latency: a vector sampled at edge N appears on `out_data` with `out_valid`=1 after edge N+1, provided the FIFO was empty.
- Throughput: one vector per cycle when `out_ready` is held at 1.
- A new offset value applies to vectors sampled on the edge after the write or LOAD edge. A vector already in S1 keeps its old correction.
- Calibration length: LOAD occurs one cycle after the 2^AVG_LOG2-th accumulated vector. `cal_done` is high for exactly one cycle, coincident with `cal_busy` falling.
- Mid-operation reset: all state returns to reset values immediately and asynchronously. The FIFO contents are discarded.

## Test plan
- Conversion: `en`=1, offsets 0, all lanes =0x100, then 0x000, then 0x1FF → `out_data` lanes 0, −256, +255, each appearing 2 edges after its sample.
- Offset and saturation: write `offset[3]`=+10, lane 3 input =0x000 → output −256 (saturated). Write `offset[3]`=−10, input 0x1FF → +255. Lane 3 input 0x110 with offset +10 → +6.
- Backpressure: `out_ready`=0 for 10 cycles of continuous input → FIFO_DEPTH vectors retained in order, `ovf`=1, head stable. A `clr_ovf` pulse clears `ovf`. Full FIFO with simultaneous push and pop → no drop.
- Calibration: lane i held at 0x100+i+5, `cal_start` → `cal_busy` high for 2^AVG_LOG2+1 cycles, then `cal_done`, `offset[i]`=i+5. Subsequent outputs are 0 on all lanes.
- Negative floor: lane 0 alternates 0x0FF/0x0FE → `offset[0]`=−2 (floor of −1.5).
- Abort: `en`→0 midway through ACC → FSM returns to IDLE, `cal_done` never pulses, offsets unchanged. `rst_n` asserted with the FIFO full → `out_valid`=0 immediately.

Source files
------------

// File: rtl/adc_lane_rx.sv
// Capture path for the 8-way interleaved SAR ADC: offset-binary to two's complement,
// per-lane offset removal with saturation, output FIFO and background mean calibration.
module adc_lane_rx #(
    parameter int WAYS       = 8,
    parameter int BITS       = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int AVG_LOG2   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WAYS*BITS-1:0]     adc_data_in,
    input  logic                     offs_wr,
    input  logic [$clog2(WAYS)-1:0]  offs_lane,
    input  logic [BITS-1:0]          offs_val,
    input  logic                     cal_start,
    output logic                     cal_busy,
    output logic                     cal_done,
    output logic [WAYS*BITS-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf,
    input  logic                     clr_ovf
);
    localparam int VW = WAYS * BITS;
    localparam int AW = BITS + AVG_LOG2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [BITS:0]   SAT_MAX   = {2'b00, {(BITS-1){1'b1}}};
    localparam logic signed [BITS:0]   SAT_MIN   = {2'b11, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0]        SAT_MAX_W = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0]        SAT_MIN_W = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_LOAD} cal_state_t;

    cal_state_t              state_q, state_d;
    logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
    logic signed [AW-1:0]    acc_q [WAYS];
    logic signed [AW-1:0]    acc_d [WAYS];
    logic signed [BITS-1:0]  offset_q [WAYS];
    logic signed [BITS-1:0]  offset_d [WAYS];
    logic                    cal_done_q, cal_done_d;

    logic [VW-1:0]           s1_data_q, s1_data_d;
    logic                    s1_valid_q, s1_valid_d;

    logic [VW-1:0]           fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    push, pop;

    logic signed [BITS-1:0]  conv [WAYS];
    logic [VW-1:0]           corr_vec;

    // Per-lane datapath: flip the MSB, subtract offset one bit wider, clamp.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
        logic signed [BITS:0] diff;
        assign conv[gi] = {~adc_data_in[gi*BITS+BITS-1], adc_data_in[gi*BITS +: BITS-1]};
        assign diff     = {conv[gi][BITS-1], conv[gi]} - {offset_q[gi][BITS-1], offset_q[gi]};
        assign corr_vec[gi*BITS +: BITS] = (diff > SAT_MAX) ? SAT_MAX_W :
                                           (diff < SAT_MIN) ? SAT_MIN_W : diff[BITS-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        offset_d   = offset_q;
        cal_done_d = 1'b0;
        if (offs_wr) begin
            offset_d[offs_lane] = offs_val;
        end
        case (state_q)
            ST_IDLE: begin
                if (cal_start && en) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                    for (int i = 0; i < WAYS; i++) acc_d[i] = '0;
                end
            end
            ST_ACC: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < WAYS; i++) begin
                        acc_d[i] = acc_q[i] + {{AVG_LOG2{conv[i][BITS-1]}}, conv[i]};
                    end
                    cnt_d = cnt_q + AVG_LOG2'(1);
                    if (&cnt_q) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Taking the upper bits of the sum is an arithmetic shift (floor).
                for (int i = 0; i < WAYS; i++) offset_d[i] = acc_q[i][AW-1:AVG_LOG2];
                cal_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d = en;
        s1_data_d  = en ? corr_vec : s1_data_q;

        pop  = (count_q != '0) && out_ready;
        push = s1_valid_q && ((count_q != CW'(FIFO_DEPTH)) || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (s1_valid_q && !push) ovf_d = 1'b1;
        else if (clr_ovf)        ovf_d = 1'b0;
        else                     ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cal_done_q <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                acc_q[i]    <= '0;
                offset_q[i] <= '0;
            end
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cal_done_q <= cal_done_d;
            acc_q      <= acc_d;
            offset_q   <= offset_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= s1_data_q;
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign ovf       = ovf_q;
    assign cal_busy  = (state_q != ST_IDLE);
    assign cal_done  = cal_done_q;

endmodule

// File: tb/tb_adc_lane_rx.sv
// Directed bench for adc_lane_rx: stimulus pushes expected vectors into a queue,
// an independent monitor pops and compares whenever the stream hands a vector out.
module tb_adc_lane_rx;
    localparam int WAYS = 8;
    localparam int BITS = 9;
    localparam int VW   = WAYS * BITS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [VW-1:0]   adc_data_in = '0;
    logic            offs_wr = 1'b0;
    logic [2:0]      offs_lane = '0;
    logic [BITS-1:0] offs_val = '0;
    logic            cal_start = 1'b0;
    logic            out_ready = 1'b0;
    logic            clr_ovf = 1'b0;
    logic            cal_busy, cal_done, out_valid, ovf;
    logic [VW-1:0]   out_data;

    adc_lane_rx #(.WAYS(8), .BITS(9), .FIFO_DEPTH(4), .AVG_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adc_data_in(adc_data_in),
        .offs_wr(offs_wr), .offs_lane(offs_lane), .offs_val(offs_val),
        .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] mon_exp;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("stream_data", out_data, mon_exp);
                $display("out #%0d data=%h expected=%h", n_out, out_data, mon_exp);
                n_out++;
            end
        end
    end

    function automatic logic [VW-1:0] rep(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < WAYS; i++) r[i*BITS +: BITS] = v[BITS-1:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] ramp(input int base);
        logic [VW-1:0] r;
        int v;
        for (int i = 0; i < WAYS; i++) begin
            v = base + i;
            r[i*BITS +: BITS] = v[BITS-1:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] setl(input logic [VW-1:0] vec, input int lane, input int v);
        logic [VW-1:0] r;
        r = vec;
        r[lane*BITS +: BITS] = v[BITS-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] d, input logic [VW-1:0] e, input bit keep);
        en = 1'b1;
        adc_data_in = d;
        if (keep) exp_q.push_back(e);
        tick();
        en = 1'b0;
    endtask

    task automatic wr_off(input int lane, input int val);
        offs_wr = 1'b1;
        offs_lane = lane[2:0];
        offs_val = val[BITS-1:0];
        tick();
        offs_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        en = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", VW'(n >= 100), VW'(0));
    endtask

    task automatic run_cal(input logic [VW-1:0] d_ev, input logic [VW-1:0] d_od,
                           input logic [VW-1:0] eb_ev, input logic [VW-1:0] eb_od,
                           input logic [VW-1:0] ea_ev, input logic [VW-1:0] ea_od,
                           input int abort_at);
        int busy_n = 0;
        int done_n = 0;
        bit done_seen = 0;
        bit busy_low_at_done = 1;
        bit even;
        out_ready = 1'b1;
        cal_start = 1'b1;
        for (int c = 0; c < 270; c++) begin
            if (abort_at != 0 && c == abort_at) break;
            even = (c % 2 == 0);
            en = 1'b1;
            adc_data_in = even ? d_ev : d_od;
            if (done_seen) exp_q.push_back(even ? ea_ev : ea_od);
            else           exp_q.push_back(even ? eb_ev : eb_od);
            tick();
            cal_start = 1'b0;
            if (cal_busy) busy_n++;
            if (cal_done) begin
                done_n++;
                if (cal_busy) busy_low_at_done = 0;
                done_seen = 1;
            end
        end
        en = 1'b0;
        tick();
        if (cal_done) done_n++;
        if (abort_at != 0) begin
            chk("abort_busy_low", VW'(cal_busy), VW'(0));
            chk("abort_no_done", VW'(done_n), VW'(0));
        end else begin
            chk("cal_busy_cycles", VW'(busy_n), VW'(257));
            chk("cal_done_pulses", VW'(done_n), VW'(1));
            chk("cal_done_busy_low", VW'(busy_low_at_done), VW'(1));
        end
        drain();
    endtask

    initial begin
        #2;
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_ovf", VW'(ovf), VW'(0));
        chk("rst_cal_busy", VW'(cal_busy), VW'(0));
        chk("rst_cal_done", VW'(cal_done), VW'(0));
        #10;
        rst_n = 1'b1;
        tick();

        // Conversion and latency
        out_ready = 1'b1;
        send(rep(9'h100), rep(0), 1);
        chk("latency_s1_only", VW'(out_valid), VW'(0));
        send(rep(9'h000), rep(-256), 1);
        chk("latency_out_valid", VW'(out_valid), VW'(1));
        send(rep(9'h1FF), rep(255), 1);
        drain();

        // Offsets and saturation, including write coincident with a sample
        wr_off(3, 10);
        send(setl(rep(9'h100), 3, 9'h000), setl(rep(0), 3, -256), 1);
        wr_off(3, -10);
        send(setl(rep(9'h100), 3, 9'h1FF), setl(rep(0), 3, 255), 1);
        offs_wr = 1'b1; offs_lane = 3'd3; offs_val = 9'd10;
        send(setl(rep(9'h100), 3, 9'h110), setl(rep(0), 3, 26), 1);
        offs_wr = 1'b0;
        send(setl(rep(9'h100), 3, 9'h110), setl(rep(0), 3, 6), 1);
        drain();

        // Backpressure, overflow, clear, full with push and pop together
        wr_off(3, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send(rep(9'h100 + k), rep(k), k < 4);
            if (k >= 1) chk("head_hold", out_data, rep(0));
        end
        tick();
        chk("bp_ovf_set", VW'(ovf), VW'(1));
        chk("bp_valid", VW'(out_valid), VW'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", VW'(ovf), VW'(0));
        send(rep(9'h100 + 20), rep(20), 1);
        out_ready = 1'b1;
        tick();
        chk("full_push_pop_no_drop", VW'(ovf), VW'(0));
        drain();
        chk("full_push_pop_ovf_after", VW'(ovf), VW'(0));

        // Calibration requested while disabled is ignored
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        chk("cal_start_en0_ignored", VW'(cal_busy), VW'(0));

        // Calibration: lane i at 0x100+i+5
        run_cal(ramp(9'h105), ramp(9'h105), ramp(5), ramp(5), rep(0), rep(0), 0);

        // Negative floor on lane 0: mean -1.5 -> -2
        run_cal(setl(ramp(9'h105), 0, 9'h0FF), setl(ramp(9'h105), 0, 9'h0FE),
                setl(rep(0), 0, -6), setl(rep(0), 0, -7),
                setl(rep(0), 0, 1), rep(0), 0);
        send(setl(ramp(9'h105), 0, 9'h100), setl(rep(0), 0, 2), 1);
        drain();

        // Abort midway: offsets must be unchanged
        run_cal(setl(ramp(9'h105), 0, 9'h100), setl(ramp(9'h105), 0, 9'h100),
                setl(rep(0), 0, 2), setl(rep(0), 0, 2),
                setl(rep(0), 0, 2), setl(rep(0), 0, 2), 50);
        send(setl(ramp(9'h105), 0, 9'h100), setl(rep(0), 0, 2), 1);
        drain();

        // Asynchronous reset with the FIFO full
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(rep(9'h100 + k), rep(k), 0);
        tick();
        chk("pre_reset_valid", VW'(out_valid), VW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", VW'(out_valid), VW'(0));
        chk("async_rst_data", out_data, '0);
        chk("async_rst_ovf", VW'(ovf), VW'(0));
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(ramp(9'h105), ramp(5), 1);
        drain();

        chk("queue_empty", VW'(exp_q.size()), VW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
